// File: rtl/jzjpcc_pkg.sv
// rtl/jzjpcc_pkg.sv - shared fetch types and constants; JZJPCC_FETCH_MISALIGN_TRAP_EN adds the misaligned flag
package jzjpcc_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;
    localparam int          SKID_DEPTH      = 2;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
        logic        misaligned;
`endif
    } fetch_packet_t;

    localparam int PACKET_W = $bits(fetch_packet_t);

    function automatic fetch_packet_t make_packet(input logic [31:0] instruction,
                                                  input logic [31:0] pc);
        fetch_packet_t p;
        p.instruction = instruction;
        p.pc          = pc;
`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
        p.misaligned  = 1'b0;
`endif
        return p;
    endfunction

endpackage

// File: rtl/jzjpcc_fetch_skid_buffer.sv
// rtl/jzjpcc_fetch_skid_buffer.sv - 2-entry fetch packet FIFO with flush; head is a registered output
module jzjpcc_fetch_skid_buffer
    import jzjpcc_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [PACKET_W-1:0] push_data_i,
    input  logic                pop_i,
    input  logic                flush_i,
    output logic [PACKET_W-1:0] head_o,
    output logic [1:0]          occupancy_o
);

    fetch_packet_t entry_q [SKID_DEPTH];
    logic          head_q;
    logic [1:0]    count_q;
    logic          tail;
    logic          pop_ok;

    assign tail        = head_q ^ count_q[0];
    assign pop_ok      = pop_i && (count_q != 2'd0);
    assign head_o      = entry_q[head_q];
    assign occupancy_o = count_q;

    // Flush and push may coincide: the pushed packet becomes the only entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_q[i] <= make_packet(NOP_INSTRUCTION, 32'h0);
            end
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            head_q  <= 1'b0;
            count_q <= {1'b0, push_i};
            if (push_i) begin
                entry_q[0] <= push_data_i;
            end
        end else begin
            if (push_i) begin
                entry_q[tail] <= push_data_i;
            end
            if (pop_ok) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_ok};
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !flush_i && (count_q == 2'd2)));

endmodule

// File: rtl/jzjpcc_fetch_unit.sv
// rtl/jzjpcc_fetch_unit.sv - RV32I fetch front end: pc, imem issue, redirect; JZJPCC_FETCH_MISALIGN_TRAP_EN traps misaligned targets
module jzjpcc_fetch_unit
    import jzjpcc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR    = 32'h00000000,
    parameter int          IMEM_ADDR_WIDTH = 30
) (
    input  logic                       clock,
    input  logic                       not_reset,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instruction,
    output logic [31:0]                out_pc,
    output logic                       out_misaligned
);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    occupancy;
    logic [2:0]    pending;
    logic          pop, issue, halted, trap_redirect;
    logic          push, flush, pop_eff;
    logic [31:0]   target;
    fetch_packet_t push_pkt, trap_pkt, head_pkt;
    logic [PACKET_W-1:0] head_bits;

`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
    logic halted_q;

    assign target        = redirect_pc;
    assign trap_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign halted        = halted_q;
    assign out_misaligned = head_pkt.misaligned;

    always_comb begin
        trap_pkt            = make_packet(NOP_INSTRUCTION, redirect_pc);
        trap_pkt.misaligned = 1'b1;
    end

    // A trapped redirect parks fetch until the next redirect.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= trap_redirect;
        end
    end
`else
    assign target         = {redirect_pc[31:2], 2'b00};
    assign trap_redirect  = 1'b0;
    assign halted         = 1'b0;
    assign out_misaligned = 1'b0;
    assign trap_pkt       = make_packet(NOP_INSTRUCTION, redirect_pc);
`endif

    assign head_pkt        = head_bits;
    assign out_valid       = (occupancy != 2'd0);
    assign out_instruction = head_pkt.instruction;
    assign out_pc          = head_pkt.pc;
    assign pop             = out_valid && out_ready;

    // Buffered plus in-flight words, after this cycle's pop, must leave room for one more.
    assign pending = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = (pending <= 3'd1) && !halted;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        push          = inflight_q;
        push_pkt      = make_packet(imem_data, inflight_pc_q);
        flush         = 1'b0;
        pop_eff       = pop;
        imem_addr     = pc_q[IMEM_ADDR_WIDTH+1:2];
        if (redirect_valid) begin
            flush   = 1'b1;
            pop_eff = 1'b0;
            push    = 1'b0;
            if (trap_redirect) begin
                push     = 1'b1;
                push_pkt = trap_pkt;
            end else begin
                imem_addr     = target[IMEM_ADDR_WIDTH+1:2];
                inflight_d    = 1'b1;
                inflight_pc_d = target;
                pc_d          = target + 32'd4;
            end
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            pc_q          <= RESET_VECTOR;
            inflight_pc_q <= RESET_VECTOR;
            inflight_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    jzjpcc_fetch_skid_buffer u_skid (
        .clk_i       (clock),
        .rst_ni      (not_reset),
        .push_i      (push),
        .push_data_i (push_pkt),
        .pop_i       (pop_eff),
        .flush_i     (flush),
        .head_o      (head_bits),
        .occupancy_o (occupancy)
    );

endmodule

// File: tb/tb_jzjpcc_fetch_unit.sv
// tb/tb_jzjpcc_fetch_unit.sv - self-checking bench for jzjpcc_fetch_unit with random handshake and redirects
module tb_jzjpcc_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        not_reset = 1'b0;
    logic [29:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_misaligned;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] head_pc;

    jzjpcc_fetch_unit #(.RESET_VECTOR(32'h0), .IMEM_ADDR_WIDTH(30)) dut (
        .clock           (clock),
        .not_reset       (not_reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_misaligned  (out_misaligned)
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory: word i holds 0x1000 + i.
    always @(posedge clock) imem_data <= 32'h1000 + {2'b00, imem_addr};

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000 + {2'b00, pc[31:2]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        not_reset = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_instruction !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", out_instruction, NOP); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
        n_checks++; if (out_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b expected 0", out_misaligned); end
        n_checks++; if (imem_addr !== 30'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        not_reset = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_cycle_empty: got %b expected 0", out_valid); end
        head_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== head_pc || out_instruction !== mem_word(head_pc)) begin
                n_fail++;
                $display("FAIL stream_start: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                         out_valid, out_pc, out_instruction, head_pc, mem_word(head_pc));
            end
            if (i < 3) head_pc = head_pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== head_pc || out_instruction !== mem_word(head_pc)) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b pc=%h ins=%h expected v=1 pc=%h", out_valid, out_pc, out_instruction, head_pc);
            end
            n_checks++;
            if (imem_addr !== 30'((head_pc + 32'd8) >> 2)) begin
                n_fail++;
                $display("FAIL stall_freeze: got addr=%h expected %h", imem_addr, (head_pc + 32'd8) >> 2);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            head_pc = head_pc + 32'd4;
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== head_pc || out_instruction !== mem_word(head_pc)) begin
                n_fail++;
                $display("FAIL resume_seq: got v=%b pc=%h ins=%h expected v=1 pc=%h", out_valid, out_pc, out_instruction, head_pc);
            end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++; if (imem_addr !== 30'h40) begin n_fail++; $display("FAIL redirect_addr: got %h expected 40", imem_addr); end
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_bubble: got %b expected 0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instruction !== 32'h1040) begin
            n_fail++;
            $display("FAIL redirect_target: got v=%b pc=%h ins=%h expected v=1 pc=100 ins=1040", out_valid, out_pc, out_instruction);
        end
        tick();
        n_checks++; if (out_pc !== 32'h104 || out_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_next: got v=%b pc=%h expected v=1 pc=104", out_valid, out_pc); end
        head_pc = 32'h104;
    endtask

    task automatic test_redirect_stalled();
        out_ready = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (out_pc !== head_pc || out_valid !== 1'b1) begin n_fail++; $display("FAIL prestall_hold: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, head_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stalled_flush: got %b expected 0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instruction !== mem_word(32'h200)) begin
            n_fail++;
            $display("FAIL stalled_target: got v=%b pc=%h ins=%h expected v=1 pc=200", out_valid, out_pc, out_instruction);
        end
        tick();
        n_checks++; if (out_pc !== 32'h200 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stalled_target_hold: got v=%b pc=%h expected v=1 pc=200", out_valid, out_pc); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_pc !== 32'h204 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stalled_resume: got v=%b pc=%h expected v=1 pc=204", out_valid, out_pc); end
        head_pc = 32'h204;
    endtask

    task automatic test_reset_mid();
        tick();
        not_reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_instruction !== NOP || out_pc !== 32'h0) begin n_fail++; $display("FAIL midreset_out: got ins=%h pc=%h expected ins=%h pc=0", out_instruction, out_pc, NOP); end
        n_checks++; if (imem_addr !== 30'h0) begin n_fail++; $display("FAIL midreset_addr: got %h expected 0", imem_addr); end
        tick();
        not_reset = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_empty: got %b expected 0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'h1000) begin
            n_fail++;
            $display("FAIL midreset_refetch: got v=%b pc=%h ins=%h expected v=1 pc=0 ins=1000", out_valid, out_pc, out_instruction);
        end
        head_pc = 32'h0;
    endtask

    task automatic test_misalign();
        logic [29:0] addr_hold;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h102 || out_misaligned !== 1'b1 || out_instruction !== NOP) begin
            n_fail++;
            $display("FAIL misalign_entry: got v=%b pc=%h mis=%b ins=%h expected v=1 pc=102 mis=1 ins=%h",
                     out_valid, out_pc, out_misaligned, out_instruction, NOP);
        end
        addr_hold = imem_addr;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || imem_addr !== addr_hold) begin
                n_fail++;
                $display("FAIL misalign_halt: got v=%b addr=%h expected v=0 addr=%h", out_valid, imem_addr, addr_hold);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_resume: got v=%b pc=%h mis=%b expected v=1 pc=0 mis=0", out_valid, out_pc, out_misaligned);
        end
        head_pc = 32'h0;
`else
        addr_hold = imem_addr;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_ignore_bubble: got %b expected 0 (addr %h)", out_valid, addr_hold); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_misaligned !== 1'b0 || out_instruction !== mem_word(32'h100)) begin
            n_fail++;
            $display("FAIL lsb_ignore_target: got v=%b pc=%h mis=%b ins=%h expected v=1 pc=100 mis=0",
                     out_valid, out_pc, out_misaligned, out_instruction);
        end
        head_pc = 32'h100;
`endif
    endtask

    task automatic test_random();
        logic        prev_hold = 1'b0;
        logic        prev_pop = 1'b0;
        logic [31:0] prev_pc = 32'h0;
        logic [31:0] prev_instr = 32'h0;
        logic [31:0] tgt = 32'h0;
        logic        rdy;
        int          since_redirect = 99;
        for (int i = 0; i < 600; i++) begin
            if (since_redirect == 1) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_flush: got %b expected 0 at iter %0d", out_valid, i); end
            end
            if (since_redirect == 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== tgt) begin
                    n_fail++; $display("FAIL rand_target: got v=%b pc=%h expected v=1 pc=%h at iter %0d", out_valid, out_pc, tgt, i);
                end
            end
            if (prev_hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instruction !== prev_instr) begin
                    n_fail++; $display("FAIL rand_stall_hold: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                                       out_valid, out_pc, out_instruction, prev_pc, prev_instr);
                end
            end
            if (prev_pop) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_no_bubble: got %b expected 1 at iter %0d", out_valid, i); end
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_pc !== head_pc || out_instruction !== mem_word(head_pc)) begin
                    n_fail++; $display("FAIL rand_head: got pc=%h ins=%h expected pc=%h ins=%h at iter %0d",
                                       out_pc, out_instruction, head_pc, mem_word(head_pc), i);
                end
            end
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) begin
                tgt            = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                head_pc        = tgt;
                since_redirect = 0;
                prev_pop       = 1'b0;
                prev_hold      = 1'b0;
            end else begin
                redirect_valid = 1'b0;
                prev_pop       = out_valid && rdy;
                prev_hold      = out_valid && !rdy;
                prev_pc        = out_pc;
                prev_instr     = out_instruction;
                if (out_valid && rdy) head_pc = head_pc + 32'd4;
            end
            out_ready = rdy;
            tick();
            if (since_redirect < 99) since_redirect++;
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stalled();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jzjpcc_fetch_unit.md
Name: jzjpcc_fetch_unit

Overview:
Instruction fetch front end of the jzjpcc pipelined RV32I core. It owns the PC and drives the word address of the synchronous-read instruction memory, which has 1-cycle read latency. It buffers returned words in a 2-entry skid buffer and hands {instruction, pc} to decode over a valid/ready handshake. Branch/jump redirects from execute squash all wrong-path work.

Parameters:
RESET_VECTOR, 32'h00000000, PC loaded at reset; bits [1:0] must be 0
IMEM_ADDR_WIDTH, 30, width of the word address to instruction memory

Ports:
clock  input  1  core clock, all state on rising edge
not_reset  input  1  asynchronous active-low reset
imem_addr  output  IMEM_ADDR_WIDTH  word address presented this cycle; data returns next cycle
imem_data  input  32  read data for the address presented last cycle
redirect_valid  input  1  execute requests PC change
redirect_pc  input  32  redirect target
out_valid  output  1  out_instruction/out_pc hold a valid fetched instruction
out_ready  input  1  decode accepts this cycle
out_instruction  output  32  fetched instruction
out_pc  output  32  PC of out_instruction
out_misaligned  output  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (async, not_reset=0):
  - pc=RESET_VECTOR; buffer empty; inflight=0.
  - out_valid=0; out_instruction=32'h00000013 (NOP); out_pc=0; out_misaligned=0.
  - imem_addr=RESET_VECTOR[31:2].
- imem_addr is combinational from pc: pc[IMEM_ADDR_WIDTH+1:2]. When a redirect is taken it is redirect_pc[...:2] instead.
- Issue rule, evaluated every cycle:
  - issue when (occupancy + inflight - pop) <= 1, where pop = out_valid & out_ready.
  - On issue: inflight_next=1, inflight_pc=pc, pc_next=pc+4 (wraps modulo 2^32).
  - Otherwise pc holds and imem_addr re-presents pc.
- Arrival: if inflight=1, write {imem_data, inflight_pc} into the buffer tail at the clock edge. The issue rule guarantees no overflow. Writing while full is an assertion failure.
- Output: registered from buffer head. out_valid = (occupancy != 0). Pop advances the head.
- Latency and throughput:
  - First instruction reaches out_valid=1 two cycles after reset release.
  - With out_ready held high, throughput is 1 instruction/cycle.
- Stall: out_ready=0 holds the out_* outputs stable. Fetch continues until the buffer plus the in-flight request reach 2 entries, then pc freezes.
- Redirect (highest priority):
  - At the edge: buffer cleared, inflight cleared (the arriving wrong-path word is dropped), pc_next=redirect_pc+4.
  - redirect_pc is issued the same cycle via the combinational imem_addr override, with inflight_next=1.
  - Any pop in the redirect cycle is void; decode flushes on redirect itself.
  - out_valid=0 the cycle after redirect. The target instruction appears 2 cycles after redirect.
- Simultaneous redirect + stall: redirect wins; the buffer is flushed regardless of out_ready.
- Reset mid-operation: all state returns to reset values immediately. In-flight memory data is ignored.

Optional Feature:
JZJPCC_FETCH_MISALIGN_TRAP_EN
- Defined:
  - A redirect with redirect_pc[1:0]!=0 is not issued to memory. Instead one buffer entry is pushed with out_instruction=NOP, out_pc=redirect_pc, out_misaligned=1.
  - pc then freezes (no issue) until the next redirect.
  - out_misaligned follows the buffer head.
- Undefined:
  - redirect_pc[1:0] are ignored (target forced to a word boundary).
  - out_misaligned is tied 0 and the extra buffer field is removed.

Decomposition:
- Package jzjpcc_pkg:
  - NOP_INSTRUCTION constant (32'h00000013).
  - fetch_packet_t struct {instruction[31:0], pc[31:0], misaligned}.
  - SKID_DEPTH=2.
- Sub-module jzjpcc_fetch_skid_buffer:
  - 2-entry FIFO of fetch_packet_t with push, pop and flush, occupancy output, async active-low reset.
  - The top holds the pc, inflight and issue logic.

Test Plan:
- Release reset with RESET_VECTOR=0, memory word i = 0x1000+i, out_ready=1 -> cycle 2 out_valid=1, out_instruction=0x1000, out_pc=0; consecutive cycles give pc 4, 8, 12, no bubbles.
- Streaming, then out_ready=0 for 5 cycles -> out_* stable. imem_addr freezes once occupancy+inflight=2. On resume, pcs continue with none skipped or duplicated.
- Redirect to 0x100 while streaming -> next cycle out_valid=0. Two cycles later out_pc=0x100, out_instruction=mem[0x40]. No wrong-path pc is ever valid after the redirect edge.
- Redirect to 0x200 while stalled with a full buffer -> buffer flushed. out_pc=0x200 appears 2 cycles later although out_ready was low during the redirect.
- Assert not_reset=0 mid-stream for 1 cycle -> out_valid=0 asynchronously, out_instruction=NOP. Refetch starts at RESET_VECTOR.
- (feature defined) redirect_pc=0x102 -> out_valid=1, out_pc=0x102, out_misaligned=1, imem_addr not advanced. A following redirect to 0x0 resumes normal fetch.
